// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared ALU control codes and mul/div op classification
package mips_cpu_pkg;
  localparam logic [4:0] ALU_MULTU = 5'b00111;
  localparam logic [4:0] ALU_MULT  = 5'b01000;
  localparam logic [4:0] ALU_DIV   = 5'b01111;
  localparam logic [4:0] ALU_DIVU  = 5'b10000;
  localparam logic [4:0] ALU_MTHI  = 5'b10001;
  localparam logic [4:0] ALU_MTLO  = 5'b10010;
  function automatic logic is_muldiv(input logic [4:0] op);
    return op == ALU_MULTU || op == ALU_MULT || op == ALU_DIV || op == ALU_DIVU;
  endfunction
  function automatic logic is_signed_op(input logic [4:0] op);
    return op == ALU_MULT || op == ALU_DIV;
  endfunction
  function automatic logic is_div_op(input logic [4:0] op);
    return op == ALU_DIV || op == ALU_DIVU;
  endfunction
endpackage

// File: rtl/mips_cpu_muldiv_seq_if.sv
// mips_cpu_muldiv_seq_if: controller-to-muldiv issue and HI/LO result bundle
interface mips_cpu_muldiv_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, a, b, input busy, done, hi, lo);
  modport slave(input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_step.sv
// mips_cpu_muldiv_step: one shift-add multiply or restoring divide iteration
module mips_cpu_muldiv_step #(parameter int WIDTH = 32) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dif;
  logic             ge;
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge = rem >= {1'b0, operand};
    dif = ge ? rem[WIDTH-1:0] - operand : rem[WIDTH-1:0];
    acc_nxt = div ? {dif, acc[WIDTH-2:0], ge} : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/mips_cpu_muldiv_seq.sv
// mips_cpu_muldiv_seq: iterative multiply/divide sequencer owning HI/LO
module mips_cpu_muldiv_seq import mips_cpu_pkg::*; #(parameter int WIDTH = 32) (
  input logic                  clk,
  input logic                  reset,
  mips_cpu_muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH-1:0]   opnd, hi, lo, a_mag, b_mag, quo, rem;
  logic               is_div, neg_q, neg_r, done, sgn, dop;
  assign sgn = is_signed_op(bus.op);
  assign dop = is_div_op(bus.op);
  assign a_mag = sgn && bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag = sgn && bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign prod = neg_q ? -acc : acc;
  assign quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.hi = hi;
  assign bus.lo = lo;
  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc),
    .operand(opnd),
    .div(is_div),
    .acc_nxt(acc_nxt)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (is_muldiv(bus.op)) begin
            acc <= {{WIDTH{1'b0}}, dop ? a_mag : b_mag};
            opnd <= dop ? b_mag : a_mag;
            is_div <= dop;
            neg_q <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && !(dop && bus.b == '0);
            neg_r <= sgn && bus.a[WIDTH-1];
            cnt <= CW'(WIDTH - 1);
            state <= CALC;
          end
          hi <= bus.op == ALU_MTHI ? bus.a : hi;
          lo <= bus.op == ALU_MTLO ? bus.a : lo;
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt == '0 ? cnt : cnt - 1'b1;
          state <= cnt == '0 ? FIX : CALC;
        end
        default: begin
          hi <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
          lo <= is_div ? quo : prod[WIDTH-1:0];
          done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// tb_mips_cpu_muldiv_seq: vector, corner-sequence and randomized model check of the muldiv sequencer
module tb_mips_cpu_muldiv_seq;
  import mips_cpu_pkg::*;
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  vec_t vt[10];
  mips_cpu_muldiv_seq_if #(.WIDTH(32)) bus();
  mips_cpu_muldiv_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = is_signed_op(op) ? longint'($signed(a)) : longint'(a);
    sb = is_signed_op(op) ? longint'($signed(b)) : longint'(b);
    if (!is_div_op(op)) begin
      p = sa * sb;
      return 64'(p);
    end
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int n, output logic held);
    logic [63:0] old;
    old = {bus.hi, bus.lo};
    held = 1'b1;
    n = 0;
    while (!bus.done && n < 40) begin
      if ({bus.hi, bus.lo} !== old) held = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic mdop(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp);
    int n;
    logic held;
    issue(op, a, b);
    chk({name, " busy"}, 64'(bus.busy), 64'd1);
    wait_done(n, held);
    chk({name, " latency"}, 64'(n), 64'd33);
    chk({name, " hold"}, 64'(held), 64'd1);
    chk({name, " result"}, {bus.hi, bus.lo}, exp);
    @(posedge clk);
    #1;
    chk({name, " done_pulse"}, {63'd0, bus.done}, 64'd0);
    chk({name, " idle"}, {63'd0, bus.busy}, 64'd0);
  endtask
  initial begin
    int n;
    logic held;
    logic [4:0] ops[4];
    logic [4:0] op;
    logic [31:0] ra, rb;
    vt = '{
      '{ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{ALU_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1},
      '{ALU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
      '{ALU_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF},
      '{ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      '{ALU_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF},
      '{ALU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
      '{ALU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14},
      '{ALU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD},
      '{ALU_MULT,  32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000}
    };
    ops = '{ALU_MULTU, ALU_MULT, ALU_DIV, ALU_DIVU};
    bus.start = 1'b0;
    bus.op = 5'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {61'd0, bus.busy, bus.done, |{bus.hi, bus.lo}}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    foreach (vt[i]) mdop($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, {vt[i].hi, vt[i].lo});
    issue(ALU_MTHI, 32'h00001234, 32'd0);
    chk("mthi_hi", 64'(bus.hi), 64'h1234);
    chk("mthi_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    @(posedge clk);
    #1;
    chk("mthi_after", {62'd0, bus.busy, bus.done}, 64'd0);
    issue(5'b00000, 32'hAAAA5555, 32'd1);
    chk("bad_op_ignored", {bus.hi, 31'd0, bus.busy}, {32'h00001234, 32'd0});
    issue(ALU_MULTU, 32'h00010000, 32'h00010000);
    repeat (3) @(posedge clk);
    #1;
    ra = bus.lo;
    issue(ALU_MTLO, 32'hDEADBEEF, 32'd0);
    chk("mtlo_while_busy", 64'(bus.lo), 64'(ra));
    wait_done(n, held);
    chk("mtlo_busy_latency", 64'(n), 64'd29);
    chk("mtlo_busy_result", {bus.hi, bus.lo}, 64'h00000001_00000000);
    @(posedge clk);
    #1;
    issue(ALU_DIVU, 32'd100, 32'd7);
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset", {61'd0, bus.busy, bus.done, |{bus.hi, bus.lo}}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    mdop("after_reset", ALU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    bus.start = 1'b1;
    bus.op = ALU_MULTU;
    bus.a = 32'd3;
    bus.b = 32'd4;
    @(posedge clk);
    #1;
    bus.op = ALU_DIVU;
    bus.a = 32'd20;
    bus.b = 32'd6;
    wait_done(n, held);
    chk("b2b_first_latency", 64'(n), 64'd33);
    chk("b2b_first", {bus.hi, bus.lo}, {32'd0, 32'd12});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_accept", {63'd0, bus.busy}, 64'd1);
    wait_done(n, held);
    chk("b2b_second_latency", 64'(n), 64'd33);
    chk("b2b_second", {bus.hi, bus.lo}, {32'd2, 32'd3});
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 3)];
      ra = $urandom;
      rb = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) - 32'd4 : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      mdop($sformatf("rnd%0d_op%0d", i, op), op, ra, rb, model(op, ra, rb));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
